// File: rtl/nf10_ipd_pkg.sv
// Shared definitions for the inter-packet delay stage: FSM encoding and skid buffer depth.
package nf10_ipd_pkg;

    typedef logic [1:0] ipd_state_t;

    localparam ipd_state_t IDLE = 2'd0;
    localparam ipd_state_t PKT  = 2'd1;
    localparam ipd_state_t GAP  = 2'd2;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/nf10_axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer with a registered ready; the payload is an opaque vector.
module nf10_axis_skid_buffer
    import nf10_ipd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push    = s_valid & ready_q;
    assign pop     = m_valid & m_ready;
    assign count_d = count_q + 2'(push) - 2'(pop);

    assign s_ready = ready_q;
    assign m_valid = (count_q != 2'd0);
    assign m_data  = mem[rd_ptr];

    // Ready is computed from next occupancy, so it falls in the same cycle the buffer becomes full.
    // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
            ready_q <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count_q <= count_d;
            ready_q <= (count_d < 2'(SKID_DEPTH));
        end
    end

    // NOTE: payload storage is deliberately not reset; validity lives in count_q alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: rtl/nf10_inter_packet_delay.sv
// Inserts a programmable idle gap after each packet's last beat; packets pass through unmodified.
module nf10_inter_packet_delay
    import nf10_ipd_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_aresetn,
    input  logic                                 sw_rst,
    input  logic                                 ipd_enable,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        ipd_cycles,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic                                 gap_active,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        pkt_count
);

    localparam int PAYLOAD_W = C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH/8 + C_S_AXIS_TUSER_WIDTH + 1;

    ipd_state_t                    state_q;
    ipd_state_t                    state_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] cnt_q;
    logic [PAYLOAD_W-1:0]          in_payload;
    logic [PAYLOAD_W-1:0]          buf_payload;
    logic                          buf_valid;
    logic                          buf_ready;
    logic                          out_open;
    logic                          hs;
    logic                          last_hs;
    logic                          gap_go;

    assign in_payload = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
    assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = buf_payload;

    nf10_axis_skid_buffer #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .clr     (sw_rst),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .s_data  (in_payload),
        .m_valid (buf_valid),
        .m_ready (buf_ready),
        .m_data  (buf_payload)
    );

    assign buf_ready = m_axis_tready & out_open;
    assign hs        = m_axis_tvalid & m_axis_tready;
    assign last_hs   = hs & m_axis_tlast;
    assign gap_go    = ipd_enable && (ipd_cycles != '0);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state_q <= IDLE;
        else if (sw_rst)  state_q <= IDLE;
        else              state_q <= state_d;
    end

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hs)      state_d = m_axis_tlast ? (gap_go ? GAP : IDLE) : PKT;
            PKT:  if (last_hs) state_d = gap_go ? GAP : IDLE;
            GAP:  if (!ipd_enable || cnt_q == C_S_AXI_DATA_WIDTH'(1)) state_d = IDLE;
            default:           state_d = IDLE;
        endcase
    end

    always_comb begin
        out_open      = (state_q != GAP);
        gap_active    = (state_q == GAP);
        m_axis_tvalid = buf_valid & out_open;
    end

    // Gap length is captured only at the last-beat handshake, so ipd_cycles edits affect the next gap.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cnt_q     <= '0;
            pkt_count <= '0;
        end else if (sw_rst) begin
            cnt_q     <= '0;
            pkt_count <= '0;
        end else begin
            if (last_hs)                           cnt_q <= ipd_cycles;
            else if (state_q == GAP && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if (last_hs) pkt_count <= pkt_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_nf10_inter_packet_delay.sv
// Directed bench for the inter-packet delay stage: reset, pass-through, gaps, backpressure, corners, soft reset, wrap.
module tb_nf10_inter_packet_delay;

    typedef struct {
        int           cyc;
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    logic         clk;
    logic         aresetn;
    logic         sw_rst;
    logic         ipd_enable;
    logic [31:0]  ipd_cycles;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         gap_active;
    logic [31:0]  pkt_count;

    logic         w_valid;
    logic         w_s_ready;
    logic [255:0] w_m_tdata;
    logic [31:0]  w_m_tstrb;
    logic [127:0] w_m_tuser;
    logic         w_m_tvalid;
    logic         w_m_tlast;
    logic         w_gap;
    logic [3:0]   w_pkt_count;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    rdy_rand = 0;
    beat_t out_q[$];
    beat_t exp_q[$];
    int    in_cyc_q[$];
    int    gap_cycles = 0;
    int    gap_viol = 0;
    int    gap_stall = 0;
    int    stable_viol = 0;

    nf10_inter_packet_delay dut (
        .axi_aclk      (clk),
        .axi_aresetn   (aresetn),
        .sw_rst        (sw_rst),
        .ipd_enable    (ipd_enable),
        .ipd_cycles    (ipd_cycles),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .gap_active    (gap_active),
        .pkt_count     (pkt_count)
    );

    // Narrow counter instance so the counter wrap is reachable in a short run.
    nf10_inter_packet_delay #(.C_S_AXI_DATA_WIDTH(4)) dut_wrap (
        .axi_aclk      (clk),
        .axi_aresetn   (aresetn),
        .sw_rst        (1'b0),
        .ipd_enable    (1'b0),
        .ipd_cycles    (4'd0),
        .s_axis_tdata  (256'd0),
        .s_axis_tstrb  (32'd0),
        .s_axis_tuser  (128'd0),
        .s_axis_tvalid (w_valid),
        .s_axis_tready (w_s_ready),
        .s_axis_tlast  (1'b1),
        .m_axis_tdata  (w_m_tdata),
        .m_axis_tstrb  (w_m_tstrb),
        .m_axis_tuser  (w_m_tuser),
        .m_axis_tvalid (w_m_tvalid),
        .m_axis_tready (1'b1),
        .m_axis_tlast  (w_m_tlast),
        .gap_active    (w_gap),
        .pkt_count     (w_pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rdy_rand) m_tready = 1'($urandom_range(0, 1));
    end

    // Output monitor, sampled mid-cycle.
    initial begin
        beat_t b;
        beat_t held;
        bit    stalled_prev;
        stalled_prev = 0;
        forever begin
            @(negedge clk);
            b.cyc = cyc; b.d = m_tdata; b.s = m_tstrb; b.u = m_tuser; b.l = m_tlast;
            if (aresetn && m_tvalid && m_tready) out_q.push_back(b);
            if (aresetn && s_tvalid && s_tready) in_cyc_q.push_back(cyc);
            if (gap_active) gap_cycles++;
            if (gap_active && m_tvalid) gap_viol++;
            if (gap_active && !s_tready) gap_stall++;
            if (stalled_prev && aresetn && !sw_rst &&
                (!m_tvalid || b.d !== held.d || b.s !== held.s || b.u !== held.u || b.l !== held.l))
                stable_viol++;
            stalled_prev = m_tvalid && !m_tready;
            held = b;
        end
    end

    function automatic beat_t mk_beat(input int p, input int bn, input logic last);
        beat_t b;
        logic [31:0] w;
        w = {p[15:0], bn[15:0]};
        b.cyc = 0;
        b.d = {8{w}};
        b.s = w ^ 32'hA5A5_5A5A;
        b.u = {4{~w}};
        b.l = last;
        return b;
    endfunction

    function automatic bit beat_eq(input beat_t a, input beat_t b);
        return (a.d === b.d) && (a.s === b.s) && (a.u === b.u) && (a.l === b.l);
    endfunction

    task automatic clear_mon();
        out_q.delete();
        exp_q.delete();
        in_cyc_q.delete();
    endtask

    task automatic send_beat(input int p, input int bn, input logic last);
        beat_t b;
        bit    done;
        int    budget;
        b = mk_beat(p, bn, last);
        done = 0;
        budget = 200;
        s_tvalid = 1'b1; s_tdata = b.d; s_tstrb = b.s; s_tuser = b.u; s_tlast = last;
        while (!done && budget > 0) begin
            @(negedge clk);
            done = s_tready;
            @(posedge clk);
            #1;
            budget--;
        end
        if (done) exp_q.push_back(b);
        else begin
            checks++; errors++;
            $display("FAIL send_timeout: pkt %0d beat %0d never accepted, s_axis_tready stuck at 0", p, bn);
        end
    endtask

    task automatic send_pkt(input int p, input int n);
        for (int i = 0; i < n; i++) send_beat(p, i, (i == n - 1));
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_out(input int n, input string name);
        int budget;
        budget = 400;
        while (out_q.size() < n && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        checks++;
        if (out_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats, want %0d", name, out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_tvalid = 1'b1; s_tdata = '1; s_tlast = 1'b1;
        m_tready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b want 0", m_tvalid); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b want 0", s_tready); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
        checks++; if (gap_active !== 1'b0) begin errors++; $display("FAIL rst_gap_active: got %b want 0", gap_active); end
        s_tvalid = 1'b0;
        aresetn = 1'b1;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %b want 0 before first edge", s_tready); end
        @(negedge clk);
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", s_tready); end
        @(posedge clk); #1;
    endtask

    task automatic test_pass_through();
        clear_mon();
        ipd_enable = 1'b0; ipd_cycles = 32'd7; m_tready = 1'b1;
        for (int p = 0; p < 3; p++) send_pkt(p + 1, 4);
        idle(1);
        wait_out(12, "pass");
        idle(3);
        checks++;
        if (out_q.size() != 12) begin errors++; $display("FAIL pass_count: got %0d beats want 12", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size() && i < in_cyc_q.size(); i++) begin
            checks++;
            if (!beat_eq(out_q[i], exp_q[i]) || out_q[i].cyc !== in_cyc_q[i] + 1) begin
                errors++;
                $display("FAIL pass_beat%0d: got %h last %b cyc %0d want %h last %b cyc %0d",
                         i, out_q[i].d, out_q[i].l, out_q[i].cyc, exp_q[i].d, exp_q[i].l, in_cyc_q[i] + 1);
            end
        end
        if (out_q.size() == 12) begin
            checks++;
            if (out_q[11].cyc - out_q[0].cyc != 11) begin
                errors++; $display("FAIL pass_contiguous: got span %0d want 11", out_q[11].cyc - out_q[0].cyc);
            end
        end
        checks++; if (pkt_count !== 32'd3) begin errors++; $display("FAIL pass_pkt_count: got %0d want 3", pkt_count); end
    endtask

    task automatic test_gap();
        clear_mon();
        gap_cycles = 0; gap_viol = 0;
        ipd_enable = 1'b1; ipd_cycles = 32'd5; m_tready = 1'b1;
        send_pkt(10, 2);
        send_pkt(11, 2);
        idle(1);
        wait_out(4, "gap");
        idle(10);
        checks++;
        if (out_q.size() != 4) begin errors++; $display("FAIL gap_count: got %0d beats want 4", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (!beat_eq(out_q[i], exp_q[i])) begin
                errors++; $display("FAIL gap_beat%0d: got %h want %h", i, out_q[i].d, exp_q[i].d);
            end
        end
        if (out_q.size() == 4) begin
            checks++;
            if (out_q[2].cyc - out_q[1].cyc != 6) begin
                errors++; $display("FAIL gap_spacing: got %0d cycles between tlast and next beat want 6", out_q[2].cyc - out_q[1].cyc);
            end
            checks++;
            if (out_q[1].cyc - out_q[0].cyc != 1 || out_q[3].cyc - out_q[2].cyc != 1) begin
                errors++; $display("FAIL gap_intra_pkt: got spacings %0d,%0d want 1,1",
                                   out_q[1].cyc - out_q[0].cyc, out_q[3].cyc - out_q[2].cyc);
            end
        end
        checks++; if (gap_cycles != 10) begin errors++; $display("FAIL gap_active_cycles: got %0d want 10", gap_cycles); end
        checks++; if (gap_viol != 0) begin errors++; $display("FAIL gap_valid_during_gap: got %0d cycles want 0", gap_viol); end
        checks++; if (pkt_count !== 32'd5) begin errors++; $display("FAIL gap_pkt_count: got %0d want 5", pkt_count); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        gap_stall = 0;
        ipd_enable = 1'b1; ipd_cycles = 32'd3; m_tready = 1'b1;
        send_pkt(30, 1);
        send_pkt(31, 4);
        idle(1);
        wait_out(5, "bp_fill");
        idle(6);
        checks++; if (gap_stall != 2) begin errors++; $display("FAIL bp_ready_in_gap: got %0d stalled gap cycles want 2", gap_stall); end
        if (out_q.size() == 5) begin
            checks++;
            if (out_q[1].cyc - out_q[0].cyc != 4) begin
                errors++; $display("FAIL bp_fill_spacing: got %0d want 4", out_q[1].cyc - out_q[0].cyc);
            end
        end

        clear_mon();
        stable_viol = 0;
        rdy_rand = 1'b1;
        send_pkt(20, 3);
        send_pkt(21, 1);
        send_pkt(22, 4);
        idle(1);
        wait_out(8, "bp_rand");
        rdy_rand = 1'b0; m_tready = 1'b1;
        idle(6);
        checks++;
        if (out_q.size() != 8) begin errors++; $display("FAIL bp_count: got %0d beats want 8", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (!beat_eq(out_q[i], exp_q[i])) begin
                errors++; $display("FAIL bp_beat%0d: got %h last %b want %h last %b", i, out_q[i].d, out_q[i].l, exp_q[i].d, exp_q[i].l);
            end
            if (out_q[i].l && i + 1 < out_q.size()) begin
                checks++;
                if (out_q[i + 1].cyc - out_q[i].cyc < 4) begin
                    errors++; $display("FAIL bp_gap%0d: got %0d cycles want >= 4", i, out_q[i + 1].cyc - out_q[i].cyc);
                end
            end
        end
        checks++; if (stable_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stable_viol); end
    endtask

    task automatic test_corners();
        int x;
        // Single-beat packets with a one-cycle gap.
        clear_mon();
        ipd_enable = 1'b1; ipd_cycles = 32'd1; m_tready = 1'b1;
        for (int p = 40; p < 44; p++) send_pkt(p, 1);
        idle(1);
        wait_out(4, "n1");
        idle(3);
        for (int i = 1; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i].cyc - out_q[i - 1].cyc != 2 || !beat_eq(out_q[i], exp_q[i])) begin
                errors++; $display("FAIL n1_alternate%0d: got spacing %0d data %h want 2 data %h",
                                   i, out_q[i].cyc - out_q[i - 1].cyc, out_q[i].d, exp_q[i].d);
            end
        end

        // Dropping ipd_enable mid-gap ends the gap on the next cycle.
        clear_mon();
        ipd_cycles = 32'd100;
        send_pkt(50, 1);
        send_pkt(51, 1);
        idle(0);
        s_tvalid = 1'b0;
        wait_out(1, "drop_first");
        repeat (5) begin @(posedge clk); #1; end
        x = cyc;
        ipd_enable = 1'b0;
        @(negedge clk);
        checks++; if (gap_active !== 1'b1) begin errors++; $display("FAIL drop_still_gap: got %b want 1", gap_active); end
        @(negedge clk);
        checks++; if (gap_active !== 1'b0) begin errors++; $display("FAIL drop_gap_end: got %b want 0", gap_active); end
        @(posedge clk); #1;
        wait_out(2, "drop");
        if (out_q.size() == 2) begin
            checks++;
            if (out_q[1].cyc != x + 1) begin errors++; $display("FAIL drop_resume: got cycle %0d want %0d", out_q[1].cyc, x + 1); end
        end

        // ipd_cycles changed mid-packet applies to that packet's gap.
        clear_mon();
        idle(2);
        ipd_enable = 1'b1; ipd_cycles = 32'd5;
        send_beat(60, 0, 1'b0);
        send_beat(60, 1, 1'b0);
        ipd_cycles = 32'd2;
        send_beat(60, 2, 1'b1);
        send_pkt(61, 1);
        idle(1);
        wait_out(4, "nchg");
        idle(4);
        if (out_q.size() == 4) begin
            checks++;
            if (out_q[3].cyc - out_q[2].cyc != 3) begin
                errors++; $display("FAIL nchg_gap: got %0d cycles want 3", out_q[3].cyc - out_q[2].cyc);
            end
        end
    endtask

    task automatic test_sw_rst();
        clear_mon();
        ipd_enable = 1'b0; m_tready = 1'b1;
        send_beat(70, 0, 1'b0);
        send_beat(70, 1, 1'b0);
        m_tready = 1'b0;
        send_beat(70, 2, 1'b0);
        s_tvalid = 1'b0;
        sw_rst = 1'b1;
        @(posedge clk); #1;
        sw_rst = 1'b0;
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL swrst_m_tvalid: got %b want 0", m_tvalid); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL swrst_s_tready: got %b want 0", s_tready); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL swrst_pkt_count: got %0d want 0", pkt_count); end
        checks++; if (gap_active !== 1'b0) begin errors++; $display("FAIL swrst_gap_active: got %b want 0", gap_active); end
        @(negedge clk);
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL swrst_ready_after: got %b want 1", s_tready); end
        @(posedge clk); #1;
        clear_mon();
        m_tready = 1'b1;
        send_pkt(71, 2);
        idle(1);
        wait_out(2, "swrst_clean");
        idle(3);
        checks++;
        if (out_q.size() != 2) begin errors++; $display("FAIL swrst_clean_count: got %0d beats want 2", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (!beat_eq(out_q[i], exp_q[i])) begin
                errors++; $display("FAIL swrst_clean_beat%0d: got %h want %h", i, out_q[i].d, exp_q[i].d);
            end
        end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL swrst_pkt_count_after: got %0d want 1", pkt_count); end
    endtask

    task automatic test_wrap();
        int acc;
        int budget;
        acc = 0; budget = 200;
        w_valid = 1'b1;
        while (acc < 15 && budget > 0) begin
            @(negedge clk);
            if (w_s_ready) acc++;
            @(posedge clk); #1;
            budget--;
        end
        w_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (w_pkt_count !== 4'hF) begin errors++; $display("FAIL wrap_max: got %h want f", w_pkt_count); end
        @(posedge clk); #1;
        w_valid = 1'b1;
        acc = 0; budget = 20;
        while (acc < 1 && budget > 0) begin
            @(negedge clk);
            if (w_s_ready) acc++;
            @(posedge clk); #1;
            budget--;
        end
        w_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (w_pkt_count !== 4'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", w_pkt_count); end
    endtask

    initial begin
        aresetn = 1'b0; sw_rst = 1'b0; ipd_enable = 1'b0; ipd_cycles = '0;
        s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b1; w_valid = 1'b0;
        test_reset();
        test_pass_through();
        test_gap();
        test_backpressure();
        test_corners();
        test_sw_rst();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
